// File: rtl/contador_param.sv
// Parametrised cascaded up/down/load counter with per-segment carry-out,
// optional saturating arithmetic and a saturation-hit pulse.
module contador_param #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int STEP  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enb,
    input  logic [1:0]             modo,
    input  logic                   sat,
    input  logic [WIDTH-1:0]       D,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH/SEG-1:0]   RCO,
    output logic                   SAT_HIT
);
    localparam int NSEG = WIDTH / SEG;
    localparam logic [WIDTH-1:0] STEPV = WIDTH'(STEP);

    logic             up;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] r;
    logic [NSEG-1:0]  cy;

    always_comb begin
        up   = (modo == 2'b00);
        opnd = (modo == 2'b10) ? STEPV : WIDTH'(1);
        r    = up ? (Q + opnd) : (Q - opnd);
    end

    // Carry out of the low K bits: lo + op >= 2^K  <=>  lo > ~op.
    // Borrow out of the low K bits: lo < op.
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        localparam int K = (i + 1) * SEG;
        assign cy[i] = up ? (Q[K-1:0] > ~opnd[K-1:0])
                          : (Q[K-1:0] <  opnd[K-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Q       <= '0;
            RCO     <= '0;
            SAT_HIT <= 1'b0;
        end else if (!enb) begin
            RCO     <= '0;
            SAT_HIT <= 1'b0;
        end else if (modo == 2'b11) begin
            Q       <= D;
            RCO     <= '0;
            SAT_HIT <= 1'b0;
        end else if (sat && cy[NSEG-1]) begin
            Q       <= up ? '1 : '0;
            RCO     <= '0;
            SAT_HIT <= 1'b1;
        end else begin
            Q       <= r;
            RCO     <= cy;
            SAT_HIT <= 1'b0;
        end
    end
endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: directed vectors plus a randomised run,
// two configurations checked every cycle against an arithmetic model.
module tb_contador_param;
    logic        clk = 1'b0;
    logic        reset, enb, sat;
    logic [1:0]  modo;
    logic [15:0] dA;
    logic [11:0] dB;
    logic [15:0] qA;
    logic [11:0] qB;
    logic [3:0]  rcoA, rcoB;
    logic        shA, shB;

    int nerr = 0;
    int nchk = 0;

    typedef struct packed {
        longint q;
        int     rco;
        bit     sh;
    } mres_t;

    mres_t mA = '0;
    mres_t mB = '0;
    bit    mvalid = 1'b0;

    always #5 clk = ~clk;

    contador_param #(.WIDTH(16), .SEG(4), .STEP(3)) dutA (
        .clk(clk), .reset(reset), .enb(enb), .modo(modo), .sat(sat),
        .D(dA), .Q(qA), .RCO(rcoA), .SAT_HIT(shA)
    );

    contador_param #(.WIDTH(12), .SEG(3), .STEP(5)) dutB (
        .clk(clk), .reset(reset), .enb(enb), .modo(modo), .sat(sat),
        .D(dB), .Q(qB), .RCO(rcoB), .SAT_HIT(shB)
    );

    function automatic mres_t mstep(input int w, input int seg,
                                    input int step, input longint q,
                                    input logic rst, input logic e,
                                    input logic [1:0] m, input logic s,
                                    input longint d);
        mres_t  o;
        longint mx, op, r, lo, ol, pk;
        bit     upd, ovf;
        o  = '0;
        mx = longint'(1) << w;
        if (rst) return o;
        if (!e) begin
            o.q = q;
            return o;
        end
        if (m == 2'b11) begin
            o.q = d % mx;
            return o;
        end
        op  = (m == 2'b10) ? longint'(step) : 1;
        upd = (m == 2'b00);
        r   = upd ? q + op : q - op;
        for (int i = 0; i < w / seg; i++) begin
            pk = longint'(1) << ((i + 1) * seg);
            lo = q % pk;
            ol = op % pk;
            if (upd ? (lo + ol >= pk) : (lo < ol))
                o.rco = o.rco | (1 << i);
        end
        ovf = upd ? (r >= mx) : (r < 0);
        if (s && ovf) begin
            o.q   = upd ? mx - 1 : 0;
            o.rco = 0;
            o.sh  = 1'b1;
        end else begin
            o.q = (r + mx) % mx;
        end
        return o;
    endfunction

    always @(posedge clk) begin
        mA <= mstep(16, 4, 3, mA.q, reset, enb, modo, sat, longint'(dA));
        mB <= mstep(12, 3, 5, mB.q, reset, enb, modo, sat, longint'(dB));
        if (reset) mvalid <= 1'b1;
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            check("A.Q",       longint'(qA),   mA.q);
            check("A.RCO",     longint'(rcoA), longint'(mA.rco));
            check("A.SAT_HIT", longint'(shA),  longint'(mA.sh));
            check("B.Q",       longint'(qB),   mB.q);
            check("B.RCO",     longint'(rcoB), longint'(mB.rco));
            check("B.SAT_HIT", longint'(shB),  longint'(mB.sh));
        end
    end

    task automatic step(input logic e, input logic [1:0] m,
                        input logic s, input logic [15:0] d);
        enb  = e;
        modo = m;
        sat  = s;
        dA   = d;
        dB   = d[11:0];
        @(negedge clk);
    endtask

    task automatic expA(input string name, input logic [15:0] q,
                        input logic [3:0] rco, input logic sh);
        check({name, ".Q"},   longint'(qA),   longint'(q));
        check({name, ".RCO"}, longint'(rcoA), longint'(rco));
        check({name, ".SH"},  longint'(shA),  longint'(sh));
    endtask

    initial begin
        reset = 1'b1;
        enb   = 1'b0;
        modo  = 2'b00;
        sat   = 1'b0;
        dA    = '0;
        dB    = '0;
        repeat (2) @(negedge clk);
        expA("rst0", 16'h0000, 4'b0000, 1'b0);
        reset = 1'b0;

        step(1, 2'b11, 0, 16'hABCD);
        expA("ld", 16'hABCD, 4'b0000, 1'b0);
        reset = 1'b1;
        step(1, 2'b11, 0, 16'h1234);
        expA("rst", 16'h0000, 4'b0000, 1'b0);
        reset = 1'b0;

        step(1, 2'b11, 0, 16'h00FF);
        step(1, 2'b00, 0, 16'h0000);
        expA("segcy", 16'h0100, 4'b0011, 1'b0);
        step(1, 2'b00, 0, 16'h0000);
        expA("segcy2", 16'h0101, 4'b0000, 1'b0);

        step(1, 2'b11, 0, 16'hFFFF);
        step(1, 2'b00, 0, 16'h0000);
        expA("wrap", 16'h0000, 4'b1111, 1'b0);
        step(1, 2'b11, 0, 16'hFFFF);
        step(1, 2'b00, 1, 16'h0000);
        expA("satup", 16'hFFFF, 4'b0000, 1'b1);

        step(1, 2'b11, 0, 16'h0001);
        step(1, 2'b10, 0, 16'h0000);
        expA("dstep", 16'hFFFE, 4'b1111, 1'b0);
        step(1, 2'b11, 0, 16'h0001);
        step(1, 2'b10, 1, 16'h0000);
        expA("satdn", 16'h0000, 4'b0000, 1'b1);
        step(1, 2'b11, 0, 16'h0010);
        step(1, 2'b01, 0, 16'h0000);
        expA("dn1", 16'h000F, 4'b0001, 1'b0);

        step(1, 2'b11, 0, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b00, 0, 16'hFFFF);
            expA("hold", 16'h0005, 4'b0000, 1'b0);
        end
        step(1, 2'b11, 0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(1, 2'b01, 1, 16'h0000);
            expA("satsus", 16'h0000, 4'b0000, 1'b1);
        end

        for (int n = 0; n < 10000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            enb   = ($urandom_range(0, 7) != 0);
            modo  = 2'($urandom_range(0, 3));
            sat   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       dA = 16'h0000;
                1:       dA = 16'hFFFF;
                2:       dA = 16'h0001;
                default: dA = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       dB = 12'h000;
                1:       dB = 12'hFFF;
                2:       dB = 12'h002;
                default: dB = 12'($urandom);
            endcase
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
